shape_processor_initiator: RTL and testbench

Bus initiator that drives the shape processor's SFR write/read interface from a command stream. Each accepted command (shape, operation) becomes one CTRL write, an error-flag sample and a CTRL read-back. The read-back is checked against the expected register contents and one classified response is returned. It sits between firmware-side command logic (or a testbench sequencer) and `shape_processor`, and forms the initiator end of the interface the processor responds on.

---
 rtl/shape_processor_initiator_pkg.sv | 53 +++++
 rtl/shape_processor_readback_checker.sv | 36 +++
 rtl/shape_processor_initiator.sv | 144 ++++++++++++++
 tb/tb_shape_processor_initiator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_processor_initiator_pkg.sv
// Shared encodings for the shape processor SFR interface: CTRL register layout,
// shape/operation codes, initiator response codes and initiator FSM states.
package shape_processor_modeling;

    localparam int SHAPE_W = 3;
    localparam int OP_W    = 2;

    typedef enum logic [SHAPE_W-1:0] {
        SHAPE_CIRCLE   = 3'd0,
        SHAPE_SQUARE   = 3'd1,
        SHAPE_TRIANGLE = 3'd2,
        SHAPE_HEXAGON  = 3'd3,
        KEEP_SHAPE     = 3'd7
    } shape_e;

    typedef enum logic [OP_W-1:0] {
        OP_AREA      = 2'd0,
        OP_PERIMETER = 2'd1,
        OP_SCALE     = 2'd2,
        OP_ROTATE    = 2'd3
    } operation_e;

    typedef struct packed {
        logic [26:0]        reserved;
        logic [SHAPE_W-1:0] shape;
        logic [OP_W-1:0]    operation;
    } ctrl_sfr_reg;

    typedef enum logic [1:0] {
        RESP_OK       = 2'd0,
        RESP_REJECTED = 2'd1,
        RESP_MISMATCH = 2'd2
    } resp_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ERR_SAMPLE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic ctrl_sfr_reg pack_ctrl(input logic [SHAPE_W-1:0] s,
                                              input logic [OP_W-1:0]    o);
        ctrl_sfr_reg r;
        r           = '0;
        r.shape     = s;
        r.operation = o;
        return r;
    endfunction

endpackage

// File: rtl/shape_processor_readback_checker.sv
// Combinational classification of one CTRL read-back into OK / REJECTED / MISMATCH.
module shape_processor_readback_checker
    import shape_processor_modeling::*;
(
    input  logic               err_i,
    input  ctrl_sfr_reg        rb_i,
    input  logic [SHAPE_W-1:0] cmd_shape_i,
    input  logic [OP_W-1:0]    cmd_operation_i,
    input  ctrl_sfr_reg        shadow_i,
    input  logic               shadow_valid_i,
    output resp_code_e         code_o
);

    logic shape_ok;

    always_comb begin
        code_o   = RESP_MISMATCH;
        shape_ok = 1'b1;
        if (err_i) begin
            // A rejected write must leave the register untouched.
            if (!shadow_valid_i || rb_i == shadow_i) begin
                code_o = RESP_REJECTED;
            end
        end else begin
            if (cmd_shape_i != KEEP_SHAPE) begin
                shape_ok = (rb_i.shape == cmd_shape_i);
            end else if (shadow_valid_i) begin
                shape_ok = (rb_i.shape == shadow_i.shape);
            end
            if (shape_ok && rb_i.operation == cmd_operation_i) begin
                code_o = RESP_OK;
            end
        end
    end

endmodule

// File: rtl/shape_processor_initiator.sv
// Turns each accepted (shape, operation) command into CTRL write, error sample,
// CTRL read-back and one classified response; one transaction outstanding.
module shape_processor_initiator
    import shape_processor_modeling::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [SHAPE_W-1:0]   cmd_shape,
    input  logic [OP_W-1:0]      cmd_operation,
    output logic                 write,
    output logic [31:0]          write_data,
    output logic                 read,
    input  logic [31:0]          read_data,
    input  logic                 error,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output resp_code_e           resp_code,
    output logic [31:0]          resp_ctrl,
    output logic [ERR_CNT_W-1:0] err_count,
    output state_e               state_dbg
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_e               state_q;
    logic [SHAPE_W-1:0]   cmd_shape_q;
    logic [OP_W-1:0]      cmd_op_q;
    logic                 err_q;
    logic [2:0]           lat_cnt_q;
    ctrl_sfr_reg          shadow_q;
    logic                 shadow_valid_q;
    logic                 cmd_ready_q;
    logic                 write_q;
    ctrl_sfr_reg          write_data_q;
    logic                 read_q;
    logic                 resp_valid_q;
    resp_code_e           resp_code_q;
    logic [31:0]          resp_ctrl_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [ERR_CNT_W-1:0] err_count_d;
    resp_code_e           check_code;

    shape_processor_readback_checker u_checker (
        .err_i           (err_q),
        .rb_i            (ctrl_sfr_reg'(read_data)),
        .cmd_shape_i     (cmd_shape_q),
        .cmd_operation_i (cmd_op_q),
        .shadow_i        (shadow_q),
        .shadow_valid_i  (shadow_valid_q),
        .code_o          (check_code)
    );

    always_comb begin
        err_count_d = err_count_q;
        if (resp_code_q == RESP_REJECTED && err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cmd_shape_q    <= '0;
            cmd_op_q       <= '0;
            err_q          <= 1'b0;
            lat_cnt_q      <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            cmd_ready_q    <= 1'b1;
            write_q        <= 1'b0;
            write_data_q   <= '0;
            read_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_code_q    <= RESP_OK;
            resp_ctrl_q    <= '0;
            err_count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_shape_q  <= cmd_shape;
                        cmd_op_q     <= cmd_operation;
                        cmd_ready_q  <= 1'b0;
                        write_q      <= 1'b1;
                        write_data_q <= pack_ctrl(cmd_shape, cmd_operation);
                        state_q      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    write_q <= 1'b0;
                    state_q <= ST_ERR_SAMPLE;
                end
                ST_ERR_SAMPLE: begin
                    err_q   <= error;
                    read_q  <= 1'b1;
                    state_q <= ST_READ;
                end
                ST_READ: begin
                    read_q    <= 1'b0;
                    lat_cnt_q <= 3'd1;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data is valid READ_LATENCY cycles after the read strobe.
                    if (lat_cnt_q == LAT) begin
                        shadow_q       <= ctrl_sfr_reg'(read_data);
                        shadow_valid_q <= 1'b1;
                        resp_code_q    <= check_code;
                        resp_ctrl_q    <= read_data;
                        resp_valid_q   <= 1'b1;
                        state_q        <= ST_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        err_count_q  <= err_count_d;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign write      = write_q;
    assign write_data = write_data_q;
    assign read       = read_q;
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;
    assign resp_ctrl  = resp_ctrl_q;
    assign err_count  = err_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_shape_processor_initiator.sv
// Directed bench for shape_processor_initiator: one instance at READ_LATENCY=1
// and one at READ_LATENCY=3, each with a small behavioural SFR responder.
module tb_shape_processor_initiator;
    import shape_processor_modeling::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        sel;
    logic [2:0]  cmd_shape;
    logic [1:0]  cmd_operation;
    logic        resp_ready;
    logic        err_val;
    logic [31:0] rd_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A signals
    logic        a_cmd_valid, a_cmd_ready, a_write, a_read, a_error, a_resp_valid;
    logic [31:0] a_write_data, a_read_data, a_resp_ctrl;
    resp_code_e  a_resp_code;
    logic [15:0] a_err_count;
    state_e      a_state;
    logic        a_wr_q = 1'b0;
    logic [3:0]  a_rd_pipe = '0;

    // Instance B signals
    logic        b_cmd_valid, b_cmd_ready, b_write, b_read, b_error, b_resp_valid;
    logic [31:0] b_write_data, b_read_data, b_resp_ctrl;
    resp_code_e  b_resp_code;
    logic [15:0] b_err_count;
    state_e      b_state;
    logic        b_wr_q = 1'b0;
    logic [3:0]  b_rd_pipe = '0;

    assign a_cmd_valid = cmd_valid & ~sel;
    assign b_cmd_valid = cmd_valid & sel;

    // Responder: error flag the cycle after write, read data READ_LATENCY after read.
    always @(posedge clk) begin
        a_wr_q    <= a_write;
        a_rd_pipe <= {a_rd_pipe[2:0], a_read};
        b_wr_q    <= b_write;
        b_rd_pipe <= {b_rd_pipe[2:0], b_read};
    end
    assign a_error     = a_wr_q ? err_val : 1'b0;
    assign b_error     = b_wr_q ? err_val : 1'b0;
    assign a_read_data = a_rd_pipe[LAT_A-1] ? rd_val : 32'hDEAD_BEEF;
    assign b_read_data = b_rd_pipe[LAT_B-1] ? rd_val : 32'hDEAD_BEEF;

    shape_processor_initiator #(.READ_LATENCY(LAT_A), .ERR_CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_shape(cmd_shape), .cmd_operation(cmd_operation),
        .write(a_write), .write_data(a_write_data),
        .read(a_read), .read_data(a_read_data), .error(a_error),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_code(a_resp_code), .resp_ctrl(a_resp_ctrl),
        .err_count(a_err_count), .state_dbg(a_state)
    );

    shape_processor_initiator #(.READ_LATENCY(LAT_B), .ERR_CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_shape(cmd_shape), .cmd_operation(cmd_operation),
        .write(b_write), .write_data(b_write_data),
        .read(b_read), .read_data(b_read_data), .error(b_error),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_code(b_resp_code), .resp_ctrl(b_resp_ctrl),
        .err_count(b_err_count), .state_dbg(b_state)
    );

    // Observed view of the currently selected instance
    logic        o_cmd_ready, o_write, o_read, o_resp_valid;
    logic [31:0] o_write_data, o_resp_ctrl;
    logic [1:0]  o_resp_code;
    logic [15:0] o_err_count;
    assign o_cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
    assign o_write      = sel ? b_write      : a_write;
    assign o_read       = sel ? b_read       : a_read;
    assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign o_write_data = sel ? b_write_data : a_write_data;
    assign o_resp_ctrl  = sel ? b_resp_ctrl  : a_resp_ctrl;
    assign o_resp_code  = sel ? b_resp_code  : a_resp_code;
    assign o_err_count  = sel ? b_err_count  : a_err_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [2:0] s, input logic [1:0] o);
        return {27'd0, s, o};
    endfunction

    // Waits (bounded) for resp_valid; returns the cycle count, -1 on timeout.
    task automatic wait_resp(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 20 && cycles < 0; k++) begin
            @(posedge clk); #1;
            if (o_resp_valid) cycles = k;
        end
    endtask

    task automatic handshake(input logic [15:0] exp_cnt);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("hs_resp_valid_low", 32'(o_resp_valid), 32'd0);
        chk("hs_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("hs_err_count", 32'(o_err_count), 32'(exp_cnt));
    endtask

    task automatic run_cmd(input logic [2:0] s, input logic [1:0] o, input logic e,
                           input logic [31:0] rb, input resp_code_e exp_code,
                           input logic [15:0] exp_cnt);
        int lat    = sel ? LAT_B : LAT_A;
        int rd_at  = -1;
        int rv_at  = -1;
        int extra_wr = 0;
        int overlap  = 0;
        err_val       = e;
        rd_val        = rb;
        cmd_shape     = s;
        cmd_operation = o;
        resp_ready    = 1'b0;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("write_at_n1", 32'(o_write), 32'd1);
        chk("write_data", o_write_data, pk(s, o));
        chk("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
        for (int k = 2; k <= 20 && rv_at < 0; k++) begin
            @(posedge clk); #1;
            if (o_write) extra_wr++;
            if (o_write && o_read) overlap++;
            if (o_read && rd_at < 0) rd_at = k;
            if (o_resp_valid) rv_at = k;
        end
        chk("write_single_pulse", 32'(extra_wr), 32'd0);
        chk("write_read_overlap", 32'(overlap), 32'd0);
        chk("read_at", 32'(rd_at), 32'd3);
        chk("resp_valid_at", 32'(rv_at), 32'(4 + lat));
        chk("resp_code", 32'(o_resp_code), 32'(exp_code));
        chk("resp_ctrl", o_resp_ctrl, rb);
        handshake(exp_cnt);
    endtask

    typedef struct {
        logic [2:0]  shape;
        logic [1:0]  op;
        logic        err;
        logic [31:0] rb;
        resp_code_e  code;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] held_ctrl;
        // SQUARE/AREA echoed, then illegal shape rejected with unchanged read-back
        vecs[0] = '{3'd1, 2'd0, 1'b0, 32'h04, RESP_OK,       16'd0};
        vecs[1] = '{3'd5, 2'd1, 1'b1, 32'h04, RESP_REJECTED, 16'd1};
        // KEEP_SHAPE: shadow shape SQUARE expected
        vecs[2] = '{3'd7, 2'd1, 1'b0, 32'h05, RESP_OK,       16'd1};
        vecs[3] = '{3'd7, 2'd3, 1'b0, 32'h0B, RESP_MISMATCH, 16'd1};
        // operation differs from command
        vecs[4] = '{3'd2, 2'd0, 1'b0, 32'h09, RESP_MISMATCH, 16'd1};
        // error flagged but register changed
        vecs[5] = '{3'd0, 2'd0, 1'b1, 32'h00, RESP_MISMATCH, 16'd1};
        vecs[6] = '{3'd3, 2'd2, 1'b0, 32'h0E, RESP_OK,       16'd1};
        vecs[7] = '{3'd3, 2'd3, 1'b1, 32'h0E, RESP_REJECTED, 16'd2};

        rst_n = 1'b0; cmd_valid = 1'b0; sel = 1'b0; cmd_shape = '0;
        cmd_operation = '0; resp_ready = 1'b0; err_val = 1'b0; rd_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
        chk("rst_write", 32'(a_write), 32'd0);
        chk("rst_write_data", a_write_data, 32'd0);
        chk("rst_read", 32'(a_read), 32'd0);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_resp_code", 32'(a_resp_code), 32'(RESP_OK));
        chk("rst_resp_ctrl", a_resp_ctrl, 32'd0);
        chk("rst_err_count", 32'(a_err_count), 32'd0);
        chk("rst_state", 32'(a_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].shape, vecs[i].op, vecs[i].err, vecs[i].rb,
                    vecs[i].code, vecs[i].cnt);
        end

        // Response stalled 5 cycles with cmd_valid held high
        err_val = 1'b0; rd_val = 32'h01; cmd_shape = 3'd0; cmd_operation = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        wait_resp(cyc);
        chk("stall_resp_seen", 32'(cyc > 0), 32'd1);
        held_ctrl = 32'h01;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_cmd_ready", 32'(o_cmd_ready), 32'd0);
            chk("stall_resp_valid", 32'(o_resp_valid), 32'd1);
            chk("stall_resp_code", 32'(o_resp_code), 32'(RESP_OK));
            chk("stall_resp_ctrl", o_resp_ctrl, held_ctrl);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("stall_hs_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("stall_hs_write", 32'(o_write), 32'd0);
        chk("stall_hs_resp_valid", 32'(o_resp_valid), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("next_accept_write", 32'(o_write), 32'd1);
        chk("next_accept_busy", 32'(o_cmd_ready), 32'd0);
        wait_resp(cyc);
        chk("next_resp_cycles", 32'(cyc), 32'(LAT_A + 3));
        chk("next_resp_code", 32'(o_resp_code), 32'(RESP_OK));
        handshake(16'd2);

        // Instance B: reset in the middle of WAIT
        @(negedge clk);
        sel = 1'b1;
        run_cmd(3'd1, 2'd0, 1'b0, 32'h04, RESP_OK, 16'd0);
        err_val = 1'b0; rd_val = 32'h00; cmd_shape = 3'd0; cmd_operation = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b_in_wait", 32'(b_state), 32'(ST_WAIT));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 32'(b_cmd_ready), 32'd1);
        chk("mid_rst_write", 32'(b_write), 32'd0);
        chk("mid_rst_write_data", b_write_data, 32'd0);
        chk("mid_rst_read", 32'(b_read), 32'd0);
        chk("mid_rst_resp_valid", 32'(b_resp_valid), 32'd0);
        chk("mid_rst_resp_code", 32'(b_resp_code), 32'(RESP_OK));
        chk("mid_rst_resp_ctrl", b_resp_ctrl, 32'd0);
        chk("mid_rst_state", 32'(b_state), 32'(ST_IDLE));
        chk("mid_rst_a_err_count", 32'(a_err_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (b_resp_valid) cyc++;
        end
        chk("no_resp_after_rst", 32'(cyc), 32'd0);
        // Shadow was invalidated, so KEEP_SHAPE accepts any shape.
        run_cmd(3'd7, 2'd0, 1'b0, 32'h08, RESP_OK, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
